// File: rtl/seq_left_shifter.sv
// ============================================================================
// Module      : seq_left_shifter
// Description : Multi-cycle logical left shifter. It shifts by 2 per cycle and
//               by 1 on an odd remainder, under a start/ready/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_left_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] c_TWO  = SHAMT_W'(2);
  localparam logic [SHAMT_W-1:0] c_ZERO = '0;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_data_next;
  logic [SHAMT_W-1:0] r_count;
  logic [SHAMT_W-1:0] w_count_next;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_data  <= w_data_next;
      r_count <= w_count_next;
    end
  end

  // Shift amounts at or beyond WIDTH naturally drain the register to zero.
  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_data_next  = data_in;
          w_count_next = shamt;
          w_state_next = (shamt != c_ZERO) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_count >= c_TWO) begin
          w_data_next  = r_data << 2;
          w_count_next = r_count - c_TWO;
        end else begin
          w_data_next  = r_data << 1;
          w_count_next = c_ZERO;
        end
        if (w_count_next == c_ZERO) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign ready       = (r_state == S_IDLE);
  assign busy        = (r_state == S_SHIFT);
  assign done        = (r_state == S_DONE);
  assign data_result = r_data;

endmodule

`default_nettype wire
